// File: rtl/antidroop_pkg.sv
// Shared types and default widths for the anti-droop sequencer.
package antidroop_pkg;

    localparam int unsigned DEF_DELAY_W = 8;
    localparam int unsigned DEF_WIN_W   = 16;
    localparam int unsigned DEF_OCNT_W  = 8;
    // Matches the filter's coefficient port width.
    localparam int unsigned TAPW_W      = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        ACTIVE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Clear has priority over increment; increment stops at the maximum value.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/antidroop_seq_ctrl.sv
// Per-trigger sequencer and configuration controller for the anti-droop IIR filter.
module antidroop_seq_ctrl
    import antidroop_pkg::*;
#(
    parameter int unsigned DELAY_W = DEF_DELAY_W,
    parameter int unsigned WIN_W   = DEF_WIN_W,
    parameter int unsigned OCNT_W  = DEF_OCNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trig,
    input  logic                     enable,
    input  logic [DELAY_W-1:0]       delay,
    input  logic [WIN_W-1:0]         window,
    input  logic                     clr_en_cfg,
    input  logic signed [TAPW_W-1:0] tapWeight_req,
    input  logic                     tapWeight_ld,
    input  logic                     oflowDetect,
    input  logic                     oflowClr,
    output logic                     filt_trig,
    output logic                     filt_accClr_en,
    output logic signed [TAPW_W-1:0] filt_tapWeight,
    output logic                     busy,
    output logic                     pulse_done,
    output logic                     oflow_sticky,
    output logic [OCNT_W-1:0]        oflow_count
);

    // One shared down-counter serves both the delay and the window phase.
    localparam int unsigned CNT_W = (DELAY_W > WIN_W) ? DELAY_W : WIN_W;

    seq_state_e               state;
    logic                     trig_a;
    logic                     trig_b;
    logic [CNT_W-1:0]         cnt;
    logic signed [TAPW_W-1:0] shadow;
    logic                     pending;
    logic                     wt_zeroed;

    logic                     arm_c;
    logic                     apply_c;
    logic                     ocnt_clr_c;
    logic                     ocnt_inc_c;
    logic [WIN_W-1:0]         win_m1_c;

    assign arm_c      = trig_a & ~trig_b & enable;
    assign win_m1_c   = (window == '0) ? '0 : window - WIN_W'(1);
    assign ocnt_clr_c = (state == IDLE) && arm_c;
    assign ocnt_inc_c = (state == ACTIVE) && oflowDetect;
    // Weight is (re)applied only between pulses: a new load, or restoring after an enable drop.
    assign apply_c    = enable && (state == IDLE) && (pending || wt_zeroed);

    // Two-stage trigger history for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_a <= 1'b0;
            trig_b <= 1'b0;
        end else begin
            trig_a <= trig;
            trig_b <= trig_a;
        end
    end

    // Pulse sequencer: IDLE -> DELAY -> ACTIVE, aborted to IDLE whenever enable is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            busy           <= 1'b0;
            filt_trig      <= 1'b0;
            pulse_done     <= 1'b0;
            filt_accClr_en <= 1'b0;
        end else begin
            filt_trig  <= 1'b0;
            pulse_done <= 1'b0;
            if (!enable) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm_c) begin
                            state          <= DELAY;
                            busy           <= 1'b1;
                            cnt            <= CNT_W'(delay);
                            filt_accClr_en <= clr_en_cfg;
                        end
                    end
                    DELAY: begin
                        if (cnt == '0) begin
                            state     <= ACTIVE;
                            filt_trig <= 1'b1;
                            cnt       <= CNT_W'(win_m1_c);
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    ACTIVE: begin
                        if (cnt == '0) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            pulse_done <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Tap weight shadow/pending logic; the filter only sees a new weight between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow         <= '0;
            pending        <= 1'b0;
            wt_zeroed      <= 1'b0;
            filt_tapWeight <= '0;
        end else begin
            if (tapWeight_ld) begin
                shadow <= tapWeight_req;
            end
            pending <= tapWeight_ld | (pending & ~apply_c);
            if (!enable) begin
                filt_tapWeight <= '0;
                wt_zeroed      <= 1'b1;
            end else if (apply_c) begin
                filt_tapWeight <= shadow;
                wt_zeroed      <= 1'b0;
            end
        end
    end

    // Sticky overflow flag; a coincident set beats the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            oflow_sticky <= 1'b0;
        end else if (oflowDetect) begin
            oflow_sticky <= 1'b1;
        end else if (oflowClr) begin
            oflow_sticky <= 1'b0;
        end
    end

    // Per-pulse overflow-cycle count, cleared at arm and held after the pulse.
    sat_counter #(
        .W (OCNT_W)
    ) u_ocnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (ocnt_clr_c),
        .inc   (ocnt_inc_c),
        .count (oflow_count)
    );

endmodule
